// File: rtl/mux_2x1_sync.sv
// rtl/mux_2x1_sync.sv - 2-to-1 operand-B selector with optional registered copy and select-change pulse
// Optional registers enabled by defining MUX_2X1_SYNC_REG_OUT_EN.
module mux_2x1_sync #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [DATA_WIDTH-1:0] in_1,
    input  logic [DATA_WIDTH-1:0] in_0,
    input  logic                  sel_2x1_in,
    output logic [DATA_WIDTH-1:0] mux_out,
    output logic [DATA_WIDTH-1:0] mux_q_out,
    output logic                  sel_changed_out
);

    // An X/Z select propagates as X; no resolution logic on purpose.
    assign mux_out = sel_2x1_in ? in_1 : in_0;

`ifdef MUX_2X1_SYNC_REG_OUT_EN
    logic sel_prev;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            mux_q_out       <= '0;
            sel_prev        <= 1'b0;
            sel_changed_out <= 1'b0;
        end else begin
            mux_q_out       <= mux_out;
            sel_prev        <= sel_2x1_in;
            sel_changed_out <= (sel_2x1_in != sel_prev);
        end
    end
`else
    // Purely combinational build: clock and reset are kept only for port compatibility.
    logic unused_clk_rst;
    assign unused_clk_rst  = clock_in ^ reset_in;
    assign mux_q_out       = mux_out;
    assign sel_changed_out = 1'b0;
`endif

endmodule

// File: tb/tb_mux_2x1_sync.sv
// tb/tb_mux_2x1_sync.sv - self-checking bench for mux_2x1_sync (both MUX_2X1_SYNC_REG_OUT_EN builds)
module tb_mux_2x1_sync;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a1 = '0;
    logic [W-1:0] a0 = '0;
    logic         sel = 1'b0;
    logic [W-1:0] mux_out;
    logic [W-1:0] mux_q_out;
    logic         sel_changed_out;

    int n_cmp  = 0;
    int n_fail = 0;

    mux_2x1_sync #(.DATA_WIDTH(W)) dut (
        .clock_in       (clk),
        .reset_in       (rst),
        .in_1           (a1),
        .in_0           (a0),
        .sel_2x1_in     (sel),
        .mux_out        (mux_out),
        .mux_q_out      (mux_q_out),
        .sel_changed_out(sel_changed_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         sel;
        logic [W-1:0] a1;
        logic [W-1:0] a0;
        logic [W-1:0] e_mux;
        logic [W-1:0] e_q;
        logic         e_chg;
    } vec_t;

    // Reference model: registered value and the history of selects seen since reset.
    logic [W-1:0] m_q = '0;
    logic         m_chg = 1'b0;
    logic         m_valid = 1'b0;
    bit           hist[$];

    function automatic logic [W-1:0] pick(logic s, logic [W-1:0] d1, logic [W-1:0] d0);
        logic [W-1:0] choices [2];
        choices[0] = d0;
        choices[1] = d1;
        return choices[s];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(logic r, logic s, logic [W-1:0] d1, logic [W-1:0] d0);
        bit prev;
        if (r) begin
            m_q   = '0;
            m_chg = 1'b0;
            hist.delete();
            m_valid = 1'b1;
        end else begin
            prev  = (hist.size() > 0) ? hist[$] : 1'b0;
            m_chg = (s != prev);
            m_q   = pick(s, d1, d0);
            hist.push_back(s);
            if (hist.size() > 4) void'(hist.pop_front());
        end
    endtask

    task automatic step(logic r, logic s, logic [W-1:0] d1, logic [W-1:0] d0,
                        logic use_tbl, logic [W-1:0] e_mux, logic [W-1:0] e_q, logic e_chg);
        logic [W-1:0] sel_val;
        @(negedge clk);
        rst = r;
        sel = s;
        a1  = d1;
        a0  = d0;
        sel_val = pick(s, d1, d0);
        #1;
        chk("mux_out", 32'(mux_out), 32'(sel_val));
        if (use_tbl) chk("tbl_mux_out", 32'(mux_out), 32'(e_mux));
`ifdef MUX_2X1_SYNC_REG_OUT_EN
        if (m_valid) chk("q_hold_pre_edge", 32'(mux_q_out), 32'(m_q));
`else
        chk("q_comb_pre_edge", 32'(mux_q_out), 32'(sel_val));
`endif
        @(posedge clk);
        model_edge(r, s, d1, d0);
        #1;
        chk("mux_out_post_edge", 32'(mux_out), 32'(sel_val));
`ifdef MUX_2X1_SYNC_REG_OUT_EN
        chk("mux_q_out", 32'(mux_q_out), 32'(m_q));
        chk("sel_changed_out", 32'(sel_changed_out), 32'(m_chg));
        if (use_tbl) begin
            chk("tbl_mux_q_out", 32'(mux_q_out), 32'(e_q));
            chk("tbl_sel_changed", 32'(sel_changed_out), 32'(e_chg));
        end
`else
        chk("mux_q_out_comb", 32'(mux_q_out), 32'(sel_val));
        chk("sel_changed_zero", 32'(sel_changed_out), 32'(0));
        if (use_tbl) chk("tbl_mux_q_out_comb", 32'(mux_q_out), 32'(e_mux));
`endif
    endtask

    initial begin
        vec_t tbl [14];
        // rst, sel, in_1, in_0, exp mux_out, exp mux_q_out, exp sel_changed (registered build)
        tbl[0]  = '{1'b1, 1'b1, 16'h0000, 16'h0049, 16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'h0000, 16'h0049, 16'h0000, 16'h0000, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0749, 16'h0000, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0749, 16'h0749, 16'h0749, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 16'h0000, 16'h0749, 16'h0000, 16'h0000, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0749, 16'h0749, 16'h0749, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 16'h0064, 16'h0749, 16'h0749, 16'h0749, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 16'h0064, 16'h0749, 16'h0064, 16'h0064, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 16'h0000, 16'h0749, 16'h0000, 16'h0000, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 16'h0064, 16'h0749, 16'h0064, 16'h0064, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 16'h0064, 16'h0749, 16'h0064, 16'h0000, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 16'h0064, 16'h0749, 16'h0064, 16'h0000, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 16'h0064, 16'h0749, 16'h0064, 16'h0064, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 16'h0064, 16'h0749, 16'h0064, 16'h0064, 1'b0};

        for (int i = 0; i < 14; i++)
            step(tbl[i].rst, tbl[i].sel, tbl[i].a1, tbl[i].a0,
                 1'b1, tbl[i].e_mux, tbl[i].e_q, tbl[i].e_chg);

        // Select toggling every cycle with changing data, then a held reset.
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'(i % 2), 16'(16'h1000 + i), 16'(16'h2000 + i), 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'(i % 2), 16'(16'h3000 + i), 16'(16'h4000 + i), 1'b0, '0, '0, 1'b0);

        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 15) == 0), 1'($urandom), 16'($urandom), 16'($urandom),
                 1'b0, '0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
